// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor.
// Each pipeline stage resolves one CHUNK-wide slice with a flattened
// generate/propagate look-ahead. It forwards the untouched upper operand
// slices, the finished lower sum slices and its chunk carry to the next stage.
// The last stage register is the output register. The whole pipe advances
// as one unit whenever the output register is empty or is being drained.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int NSTAGE = WIDTH / CHUNK;

  logic advance;

  // Look-ahead carries for one chunk. Every carry is built directly from the
  // generate/propagate terms and the chunk carry-in. No carry depends on the
  // carry of the neighbouring bit, so there is no ripple.
  function automatic logic [CHUNK:0] lookahead(input logic [CHUNK-1:0] gen,
                                               input logic [CHUNK-1:0] prop,
                                               input logic             cin);
    logic [CHUNK:0] cy;
    logic           term;
    cy    = '0;
    cy[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & prop[j];
      cy[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) term = term & prop[k];
        cy[i+1] = cy[i+1] | term;
      end
    end
    return cy;
  endfunction

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : stg
      // Operand bits still unprocessed when they reach this stage.
      localparam int REM = WIDTH - gi * CHUNK;

      logic                      v_in;
      logic [REM-1:0]            a_in;
      logic [REM-1:0]            b_in;
      logic                      cy_in;
      logic [CHUNK-1:0]          g;
      logic [CHUNK-1:0]          p;
      logic [CHUNK:0]            c;
      logic [CHUNK-1:0]          s_chunk;
      logic [(gi+1)*CHUNK-1:0]   s_next;
      logic                      v_reg;
      logic                      cy_reg;
      logic [(gi+1)*CHUNK-1:0]   s_reg;

      if (gi == 0) begin : head
        // The subtrahend is inverted once on entry. The +1 of the two's
        // complement enters as the stage 0 carry.
        assign v_in   = in_valid;
        assign a_in   = in1;
        assign b_in   = sub ? ~in2 : in2;
        assign cy_in  = sub | c_in;
        assign s_next = s_chunk;
      end else begin : body
        assign v_in   = stg[gi-1].v_reg;
        assign a_in   = stg[gi-1].fwd.a_reg;
        assign b_in   = stg[gi-1].fwd.b_reg;
        assign cy_in  = stg[gi-1].cy_reg;
        assign s_next = {s_chunk, stg[gi-1].s_reg};
      end

      assign g       = a_in[CHUNK-1:0] & b_in[CHUNK-1:0];
      assign p       = a_in[CHUNK-1:0] ^ b_in[CHUNK-1:0];
      assign c       = lookahead(g, p, cy_in);
      assign s_chunk = p ^ c[CHUNK-1:0];

      // Stage control and result register: valid bit, chunk carry-out and
      // the sum bits completed so far.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg  <= 1'b0;
          cy_reg <= 1'b0;
          s_reg  <= '0;
        end else if (advance) begin
          v_reg  <= v_in;
          cy_reg <= c[CHUNK];
          s_reg  <= s_next;
        end
      end

      if (gi < NSTAGE - 1) begin : fwd
        logic [REM-CHUNK-1:0] a_reg;
        logic [REM-CHUNK-1:0] b_reg;

        // Carry the unprocessed upper operand slices to the next stage.
        // The operand sign bits ride along here for the final overflow test.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (advance) begin
            a_reg <= a_in[REM-1:CHUNK];
            b_reg <= b_in[REM-1:CHUNK];
          end
        end
      end

      if (gi == NSTAGE - 1) begin : tail
        logic ovf_reg;

        // Signed overflow: the carry into the MSB differs from the carry
        // out of the MSB.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (advance) begin
            ovf_reg <= c[CHUNK] ^ c[CHUNK-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = stg[NSTAGE-1].v_reg;
  assign sum       = stg[NSTAGE-1].s_reg;
  assign c_out     = stg[NSTAGE-1].cy_reg;
  assign ovf       = stg[NSTAGE-1].tail.ovf_reg;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder.
// Three instances: the default 16/4 build, a 32/8 build and a single-stage
// 8/8 build.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst_n;

  // 16-bit, four-stage instance
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] in1, in2, sum;
  // 32-bit, four-stage instance
  logic        in_valid_w, in_ready_w, out_valid_w, c_out_w, ovf_w;
  logic [31:0] in1_w, in2_w, sum_w;
  // 8-bit, single-stage instance
  logic        in_valid_n, in_ready_n, out_valid_n, c_out_n, ovf_n;
  logic [7:0]  in1_n, in2_n, sum_n;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [17:0] exp_q[$];
  logic [15:0] bp_a [8];
  logic [15:0] bp_b [8];
  logic [7:0]  bp_s;
  logic [7:0]  bp_c;
  int          idx;
  int          got;

  cla_pipe_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in1(in1_w), .in2(in2_w), .c_in(1'b0), .sub(1'b0), .out_valid(out_valid_w),
    .out_ready(1'b1), .sum(sum_w), .c_out(c_out_w), .ovf(ovf_w)
  );

  cla_pipe_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in1(in1_n), .in2(in2_n), .c_in(1'b0), .sub(1'b0), .out_valid(out_valid_n),
    .out_ready(1'b1), .sum(sum_n), .c_out(c_out_n), .ovf(ovf_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-20s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Valid plus the packed {ovf, c_out, sum} of the 16-bit instance.
  task automatic chk_out(input string tag, input logic [15:0] e_sum,
                         input logic e_c, input logic e_ovf);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, 32'({ovf, c_out, sum}), 32'({e_ovf, e_c, e_sum}));
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s);
    in_valid = v;
    in1      = a;
    in2      = b;
    c_in     = ci;
    sub      = s;
  endtask

  // Reference {ovf, c_out, sum}; overflow from the operand/result sign rule.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    logic [15:0] bx;
    logic [16:0] r;
    logic        ov;
    bx = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + {16'd0, (s ? 1'b1 : ci)};
    ov = (a[15] == bx[15]) && (r[15] != a[15]);
    return {ov, r[16], r[15:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    out_ready  = 1'b1;
    in_valid_w = 1'b0; in1_w = '0; in2_w = '0;
    in_valid_n = 1'b0; in1_n = '0; in2_n = '0;
    bp_a = '{16'd100, 16'd32767, 16'd5000, 16'd65535, 16'd1234, 16'd40000, 16'd7, 16'd30000};
    bp_b = '{16'd200, 16'd1, 16'd6000, 16'd1, 16'd4321, 16'd30000, 16'd9, 16'd50000};
    bp_s = 8'b1010_0110;
    bp_c = 8'b0001_1001;
    #2;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", 32'({c_out, ovf}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Single beat, latency of four edges including the accept edge
    drive(1'b1, 16'd3245, 16'd16785, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("lat_e1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e2", 32'(out_valid), 32'd0);
    tick();
    chk("lat_e3", 32'(out_valid), 32'd0);
    tick();
    chk_out("basic", 16'd20030, 1'b0, 1'b0);
    tick();
    chk("basic_drop", 32'(out_valid), 32'd0);

    // Back-to-back adds
    drive(1'b1, 16'd3245, 16'd16785, 1'b1, 1'b0);  tick();
    drive(1'b1, 16'd25000, 16'd40535, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd25001, 16'd40535, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);         tick();
    chk_out("b2b_1", 16'd20031, 1'b0, 1'b0); tick();
    chk_out("b2b_2", 16'd65535, 1'b0, 1'b0); tick();
    chk_out("b2b_3", 16'd0, 1'b1, 1'b0);     tick();
    chk("b2b_drop", 32'(out_valid), 32'd0);

    // Subtract, c_in ignored
    drive(1'b1, 16'd3245, 16'd16785, 1'b1, 1'b1); tick();
    drive(1'b1, 16'd16785, 16'd3245, 1'b0, 1'b1); tick();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);        tick();
    tick();
    chk_out("sub_1", 16'd51996, 1'b0, 1'b0); tick();
    chk_out("sub_2", 16'd13540, 1'b1, 1'b0); tick();
    chk("sub_drop", 32'(out_valid), 32'd0);

    // Overflow corners
    drive(1'b1, 16'd32767, 16'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd32768, 16'd1, 1'b0, 1'b1); tick();
    drive(1'b1, 16'd65535, 16'd1, 1'b0, 1'b0); tick();
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);     tick();
    chk_out("ovf_add", 16'd32768, 1'b0, 1'b1); tick();
    chk_out("ovf_sub", 16'd32767, 1'b1, 1'b1); tick();
    chk_out("ovf_wrap", 16'd0, 1'b1, 1'b0);    tick();
    chk("ovf_drop", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for six cycles, eight beats, scoreboard
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 6);
      if (idx < 8) drive(1'b1, bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx]);
      else         drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      #1;
      if (cyc == 3) chk("bp_in_ready_hi", 32'(in_ready), 32'd1);
      if (cyc == 4 || cyc == 5) begin
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'({out_valid, ovf, c_out, sum}), 32'({1'b1, exp_q[0]}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("bp_result", 32'({ovf, c_out, sum}), 32'(exp_q[0]));
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in1, in2, c_in, sub));
        idx++;
      end
      tick();
    end
    chk("bp_count", 32'(got), 32'd8);
    chk("bp_accepted", 32'(idx), 32'd8);
    chk("bp_leftover", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with beats in flight
    out_ready = 1'b1;
    drive(1'b1, 16'd1000, 16'd2000, 1'b0, 1'b0); tick();
    drive(1'b1, 16'd11, 16'd22, 1'b0, 1'b0);     tick();
    drive(1'b1, 16'd300, 16'd400, 1'b0, 1'b0);   tick();
    drive(1'b1, 16'd5, 16'd6, 1'b0, 1'b0);       tick();
    chk_out("mid_pre", 16'd3000, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout_ovf", 32'({c_out, ovf}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

    // 32-bit build, four stages of eight bits
    chk("w_in_ready", 32'(in_ready_w), 32'd1);
    in_valid_w = 1'b1; in1_w = 32'hFFFF_FFFF; in2_w = 32'd1;
    tick();
    in_valid_w = 1'b0;
    chk("w_lat_e1", 32'(out_valid_w), 32'd0);
    tick();
    chk("w_lat_e2", 32'(out_valid_w), 32'd0);
    tick();
    chk("w_lat_e3", 32'(out_valid_w), 32'd0);
    tick();
    chk("w_valid", 32'(out_valid_w), 32'd1);
    chk("w_sum", sum_w, 32'd0);
    chk("w_cout_ovf", 32'({c_out_w, ovf_w}), 32'b10);

    // Single-stage build: one edge of latency
    in_valid_n = 1'b1; in1_n = 8'd200; in2_n = 8'd100;
    tick();
    in1_n = 8'd100; in2_n = 8'd100;
    chk("n1_valid", 32'(out_valid_n), 32'd1);
    chk("n1_result", 32'({ovf_n, c_out_n, sum_n}), 32'({1'b0, 1'b1, 8'd44}));
    tick();
    in_valid_n = 1'b0;
    chk("n2_valid", 32'(out_valid_n), 32'd1);
    chk("n2_result", 32'({ovf_n, c_out_n, sum_n}), 32'({1'b1, 1'b0, 8'd200}));
    chk("n_in_ready", 32'(in_ready_n), 32'd1);
    tick();
    chk("n_drop", 32'(out_valid_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
